// File: rtl/soft_fifo_arb.sv
`default_nettype none
// ============================================================================
// Module   : soft_fifo_arb
// Purpose  : Round-robin packet arbiter that funnels NUM_IN requester beat
//            streams into one shared soft FIFO. A grant is held until the
//            packet's last beat or until MAX_BURST beats have been sent, and
//            every new grant costs one IDLE arbitration cycle.
// Options  : define SOFT_FIFO_ARB_STATS_EN to add per-requester grant counters
//            on output grant_count.
// Revision : 1.0 - initial release
// ============================================================================
module soft_fifo_arb #(
  parameter int NUM_IN    = 4,
  parameter int WIDTH     = 512,
  parameter int MAX_BURST = 8
) (
  input  logic                                         clock,
  input  logic                                         reset_n,
  input  logic [NUM_IN-1:0]                            in_valid,
  input  logic [NUM_IN*WIDTH-1:0]                      in_data,
  input  logic [NUM_IN-1:0]                            in_last,
  output logic [NUM_IN-1:0]                            in_ready,
  output logic                                         fifo_wrreq,
  output logic [WIDTH-1:0]                             fifo_data,
  input  logic                                         fifo_full,
  output logic                                         grant_valid,
`ifdef SOFT_FIFO_ARB_STATS_EN
  output logic [NUM_IN*32-1:0]                         grant_count,
`endif
  output logic [((NUM_IN > 1) ? $clog2(NUM_IN) : 1)-1:0] grant_idx
);

  localparam int IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int BCNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [BCNT_W-1:0] BURST_LIMIT = BCNT_W'(MAX_BURST);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_IN - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BCNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic               grant_valid_q, grant_valid_d;

  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   pick_cand;
  logic [IDX_W-1:0]   next_ptr;
  logic [BCNT_W-1:0]  beat_cnt_inc;
  logic               any_valid;
  logic               g_valid;
  logic               g_last;
  logic               xfer;
  logic               burst_end;
  logic               grant_start;

  assign any_valid    = |in_valid;
  assign g_valid      = in_valid[grant_idx_q];
  assign g_last       = in_last[grant_idx_q];
  assign xfer         = fifo_wrreq;
  assign beat_cnt_inc = beat_cnt_q + 1'b1;
  assign burst_end    = (beat_cnt_inc == BURST_LIMIT);
  assign next_ptr     = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;
  assign grant_start  = (state_q == ST_IDLE) && any_valid;

  // Round-robin pick: scan downward so the nearest valid index at/after rr_ptr wins.
  always_comb begin
    pick_idx  = rr_ptr_q;
    pick_cand = rr_ptr_q;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      pick_cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_IN);
      if (in_valid[pick_cand]) begin
        pick_idx = pick_cand;
      end
    end
  end

  // Next-state logic: arbitrate in IDLE, count beats and release in GRANT.
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          state_d     = ST_GRANT;
          grant_idx_d = pick_idx;
          beat_cnt_d  = '0;
        end
      end
      ST_GRANT: begin
        if (xfer) begin
          if (g_last || burst_end) begin
            state_d    = ST_IDLE;
            beat_cnt_d = '0;
            rr_ptr_d   = next_ptr;
          end else begin
            beat_cnt_d = beat_cnt_inc;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    grant_valid_d = (state_d == ST_GRANT);
  end

  // State registers; reset abandons any grant in progress.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      grant_idx_q   <= '0;
      rr_ptr_q      <= '0;
      beat_cnt_q    <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_idx_q   <= grant_idx_d;
      rr_ptr_q      <= rr_ptr_d;
      beat_cnt_q    <= beat_cnt_d;
      grant_valid_q <= grant_valid_d;
    end
  end

  // Handshake outputs are zero-latency and forced off while reset is asserted.
  always_comb begin
    in_ready   = '0;
    fifo_wrreq = 1'b0;
    if (reset_n && (state_q == ST_GRANT)) begin
      in_ready[grant_idx_q] = !fifo_full;
      fifo_wrreq            = g_valid && !fifo_full;
    end
  end

  assign fifo_data   = in_data[int'(grant_idx_q)*WIDTH +: WIDTH];
  assign grant_valid = grant_valid_q && reset_n;
  assign grant_idx   = grant_idx_q;

`ifdef SOFT_FIFO_ARB_STATS_EN
  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_stats
    logic [31:0] cnt_q, cnt_d;

    // Count each IDLE->GRANT transition awarded to this requester.
    always_comb begin
      cnt_d = cnt_q;
      if (grant_start && (pick_idx == IDX_W'(gi))) begin
        cnt_d = cnt_q + 32'd1;
      end
    end

    // Counter register, wraps naturally at 2^32.
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign grant_count[gi*32 +: 32] = cnt_q;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_soft_fifo_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_soft_fifo_arb
// Purpose  : Self-checking bench for soft_fifo_arb. Requesters are fed from
//            per-requester packet queues; a transaction-level model tracks
//            which requester should own the FIFO and a per-requester
//            scoreboard checks that every beat arrives once and in order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_soft_fifo_arb;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int MB = 8;
  localparam int IW = 2;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [N-1:0]     in_valid;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_last;
  logic [N-1:0]     in_ready;
  logic             fifo_wrreq;
  logic [W-1:0]     fifo_data;
  logic             fifo_full;
  logic             grant_valid;
  logic [IW-1:0]    grant_idx;
`ifdef SOFT_FIFO_ARB_STATS_EN
  logic [N*32-1:0]  grant_count;
`endif

  soft_fifo_arb #(.NUM_IN(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .fifo_wrreq  (fifo_wrreq),
    .fifo_data   (fifo_data),
    .fifo_full   (fifo_full),
    .grant_valid (grant_valid),
`ifdef SOFT_FIFO_ARB_STATS_EN
    .grant_count (grant_count),
`endif
    .grant_idx   (grant_idx)
  );

  always #5 clock = ~clock;

  // Beat = {last, data}
  logic [W:0] drvq [N][$];
  logic [W:0] expq [N][$];

  int n_checks = 0;
  int n_fail   = 0;
  int seq_ctr  = 0;
  int xfer_total = 0;
  int enq_total  = 0;
  int stall_at   = -1;
  int stall_left = 0;
  int gap_pct    = 0;
  int full_pct   = 0;
  int grant_seq[$];
  bit prev_dut_gv = 1'b0;

  // Reference model: who owns the FIFO, beats sent in this grant, fairness pointer.
  bit m_gv   = 1'b0;
  int m_g    = 0;
  int m_rr   = 0;
  int m_beats = 0;

  task automatic add_packet(input int req, input int len);
    logic [W:0] b;
    for (int k = 0; k < len; k++) begin
      b = {(k == len - 1) ? 1'b1 : 1'b0, 4'(req), 12'(seq_ctr)};
      seq_ctr++;
      drvq[req].push_back(b);
      expq[req].push_back(b);
    end
  endtask

  function automatic bit busy();
    bit r = m_gv;
    for (int i = 0; i < N; i++) if (drvq[i].size() > 0) r = 1'b1;
    return r;
  endfunction

  // One clock: drive inputs, compare outputs against the model at negedge, advance model.
  task automatic cycle();
    logic [N-1:0] exp_rdy;
    logic         exp_wr;
    logic         exp_gv;
    logic [W:0]   e;
    int           k;
    for (int i = 0; i < N; i++) begin
      in_valid[i] = (drvq[i].size() > 0) && ($urandom_range(99) >= gap_pct);
      if (drvq[i].size() > 0) begin
        in_data[i*W +: W] = drvq[i][0][W-1:0];
        in_last[i]        = drvq[i][0][W];
      end else begin
        in_data[i*W +: W] = W'($urandom);
        in_last[i]        = 1'b0;
      end
    end
    if (stall_left > 0 && xfer_total == stall_at) begin
      fifo_full  = 1'b1;
      stall_left = stall_left - 1;
    end else begin
      fifo_full = ($urandom_range(99) < full_pct);
    end

    @(negedge clock);
    exp_gv  = reset_n && m_gv;
    exp_rdy = '0;
    exp_wr  = 1'b0;
    if (exp_gv) begin
      exp_rdy[m_g] = !fifo_full;
      exp_wr       = in_valid[m_g] && !fifo_full;
    end
    n_checks++;
    if (grant_valid !== exp_gv) begin
      n_fail++; $display("FAIL grant_valid: got %b expected %b at %0t", grant_valid, exp_gv, $time);
    end
    if (exp_gv) begin
      n_checks++;
      if (grant_idx !== IW'(m_g)) begin
        n_fail++; $display("FAIL grant_idx: got %0d expected %0d at %0t", grant_idx, m_g, $time);
      end
    end
    n_checks++;
    if (in_ready !== exp_rdy) begin
      n_fail++; $display("FAIL in_ready: got %b expected %b at %0t", in_ready, exp_rdy, $time);
    end
    n_checks++;
    if (fifo_wrreq !== exp_wr) begin
      n_fail++; $display("FAIL fifo_wrreq: got %b expected %b at %0t", fifo_wrreq, exp_wr, $time);
    end
    n_checks++;
    if (fifo_wrreq === 1'b1 && fifo_full === 1'b1) begin
      n_fail++; $display("FAIL wrreq_while_full: got wrreq=1 expected 0 at %0t", $time);
    end
    if (fifo_wrreq === 1'b1) begin
      n_checks++;
      if (expq[m_g].size() == 0) begin
        n_fail++; $display("FAIL fifo_data_extra: got %h expected no beat for req %0d", fifo_data, m_g);
      end else begin
        e = expq[m_g].pop_front();
        if (fifo_data !== e[W-1:0]) begin
          n_fail++; $display("FAIL fifo_data: got %h expected %h at %0t", fifo_data, e[W-1:0], $time);
        end
      end
      enq_total++;
    end
    if (grant_valid === 1'b1 && !prev_dut_gv) grant_seq.push_back(int'(grant_idx));
    prev_dut_gv = (grant_valid === 1'b1);

    for (int i = 0; i < N; i++) begin
      if (in_valid[i] && in_ready[i] === 1'b1 && drvq[i].size() > 0) begin
        void'(drvq[i].pop_front());
        xfer_total++;
      end
    end

    if (!reset_n) begin
      m_gv = 1'b0; m_rr = 0; m_beats = 0;
    end else if (!m_gv) begin
      if (|in_valid) begin
        k = 0;
        while (!in_valid[(m_rr + k) % N]) k++;
        m_g = (m_rr + k) % N;
        m_gv = 1'b1;
        m_beats = 0;
      end
    end else if (in_valid[m_g] && !fifo_full) begin
      m_beats++;
      if (in_last[m_g] || m_beats == MB) begin
        m_gv = 1'b0;
        m_rr = (m_g + 1) % N;
      end
    end

    @(posedge clock);
    #1;
  endtask

  task automatic run_drain(input int max_cycles);
    int c = 0;
    while (busy() && c < max_cycles) begin
      cycle();
      c++;
    end
    n_checks++;
    if (busy()) begin
      n_fail++; $display("FAIL drain_timeout: got busy after %0d cycles expected drained", c);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    grant_seq.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cycle();
    n_checks++;
    if (grant_valid !== 1'b0 || in_ready !== '0 || fifo_wrreq !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: got gv=%b rdy=%b wr=%b expected 0", grant_valid, in_ready, fifo_wrreq);
    end
    reset_n = 1'b1;
    cycle();
    n_checks++;
    if (grant_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_gv: got %b expected 0", grant_valid);
    end
    n_checks++;
    if (fifo_wrreq !== 1'b0 || in_ready !== '0) begin
      n_fail++; $display("FAIL post_reset_handshake: got wr=%b rdy=%b expected 0", fifo_wrreq, in_ready);
    end
  endtask

  task automatic test_round_robin();
    int base;
    do_reset();
    gap_pct = 0; full_pct = 0;
    base = enq_total;
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) add_packet(i, 1);
    run_drain(200);
    n_checks++;
    if (grant_seq.size() < 5) begin
      n_fail++; $display("FAIL rr_grant_count: got %0d expected >=5", grant_seq.size());
    end else begin
      for (int g = 0; g < 5; g++) begin
        if (grant_seq[g] != g % N) begin
          n_fail++; $display("FAIL rr_order: got %0d expected %0d at grant %0d", grant_seq[g], g % N, g);
        end
      end
    end
    n_checks++;
    if (enq_total - base != 2 * N) begin
      n_fail++; $display("FAIL rr_beats: got %0d expected %0d", enq_total - base, 2 * N);
    end
  endtask

  task automatic test_stall();
    int base;
    do_reset();
    gap_pct = 0; full_pct = 0;
    base = enq_total;
    add_packet(2, 3);
    stall_at = xfer_total + 1;
    stall_left = 4;
    run_drain(100);
    n_checks++;
    if (stall_left != 0) begin
      n_fail++; $display("FAIL stall_applied: got %0d stall cycles left expected 0", stall_left);
    end
    n_checks++;
    if (enq_total - base != 3 || expq[2].size() != 0) begin
      n_fail++; $display("FAIL stall_beats: got %0d expected 3", enq_total - base);
    end
    stall_at = -1;
  endtask

  task automatic test_burst();
    do_reset();
    gap_pct = 0; full_pct = 0;
    add_packet(1, 20);
    add_packet(3, 3);
    run_drain(300);
    n_checks++;
    if (grant_seq.size() != 4) begin
      n_fail++; $display("FAIL burst_grants: got %0d expected 4", grant_seq.size());
    end else if (grant_seq[0] != 1 || grant_seq[1] != 3 || grant_seq[2] != 1 || grant_seq[3] != 1) begin
      n_fail++; $display("FAIL burst_order: got %0d,%0d,%0d,%0d expected 1,3,1,1",
                         grant_seq[0], grant_seq[1], grant_seq[2], grant_seq[3]);
    end
    n_checks++;
    if (expq[1].size() != 0 || expq[3].size() != 0) begin
      n_fail++; $display("FAIL burst_leftover: got %0d/%0d expected 0/0", expq[1].size(), expq[3].size());
    end
  endtask

  task automatic test_reset_mid();
    int base;
    int c = 0;
    do_reset();
    gap_pct = 0; full_pct = 0;
    add_packet(2, 1);
    run_drain(50);
    add_packet(2, 10);
    base = xfer_total;
    while (xfer_total - base < 4 && c < 100) begin
      cycle();
      c++;
    end
    n_checks++;
    if (xfer_total - base != 4) begin
      n_fail++; $display("FAIL midreset_setup: got %0d beats expected 4", xfer_total - base);
    end
    add_packet(3, 1);
    add_packet(1, 1);
    base = enq_total;
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    drvq[2].delete();
    expq[2].delete();
    n_checks++;
    if (enq_total != base) begin
      n_fail++; $display("FAIL midreset_beat: got %0d beats during reset expected 0", enq_total - base);
    end
    n_checks++;
    if (grant_valid !== 1'b0 || fifo_wrreq !== 1'b0) begin
      n_fail++; $display("FAIL midreset_after: got gv=%b wr=%b expected 0", grant_valid, fifo_wrreq);
    end
    grant_seq.delete();
    run_drain(100);
    n_checks++;
    if (grant_seq.size() < 1 || grant_seq[0] != 1) begin
      n_fail++; $display("FAIL midreset_next: got %0d expected 1", (grant_seq.size() > 0) ? grant_seq[0] : -1);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    gap_pct = 0; full_pct = 0;
    add_packet(3, 1);
    run_drain(50);
    grant_seq.delete();
    add_packet(0, 1);
    add_packet(3, 1);
    run_drain(50);
    n_checks++;
    if (grant_seq.size() != 2 || grant_seq[0] != 0 || grant_seq[1] != 3) begin
      n_fail++; $display("FAIL wrap_order: got %0d grants first %0d expected 0 then 3",
                         grant_seq.size(), (grant_seq.size() > 0) ? grant_seq[0] : -1);
    end
  endtask

  task automatic test_random();
    int left = 0;
    do_reset();
    gap_pct = 30; full_pct = 25;
    for (int i = 0; i < N; i++) begin
      for (int p = 0; p < int'($urandom_range(4, 1)); p++) add_packet(i, int'($urandom_range(12, 1)));
    end
    run_drain(5000);
    for (int i = 0; i < N; i++) left += expq[i].size();
    n_checks++;
    if (left != 0) begin
      n_fail++; $display("FAIL random_leftover: got %0d beats missing expected 0", left);
    end
    gap_pct = 0; full_pct = 0;
  endtask

`ifdef SOFT_FIFO_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    gap_pct = 0; full_pct = 0;
    n_checks++;
    if (grant_count !== '0) begin
      n_fail++; $display("FAIL stats_reset: got %h expected 0", grant_count);
    end
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) add_packet(i, 1);
    run_drain(200);
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (grant_count[i*32 +: 32] !== 32'd2) begin
        n_fail++; $display("FAIL stats_count: got %0d expected 2 for req %0d", grant_count[i*32 +: 32], i);
      end
    end
  endtask
`endif

  initial begin
    reset_n   = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    in_last   = '0;
    fifo_full = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_round_robin();
    test_stall();
    test_burst();
    test_reset_mid();
    test_wrap();
    test_random();
`ifdef SOFT_FIFO_ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
